// File: rtl/hb_target_emu.sv
// hb_target_emu: synthesizable HyperBus target emulating a small HyperRAM.
// Oversamples hb_clk/hb_csn on wb_clk_i and serves memory and register-space
// bursts from an internal 2^MEM_AW x 16 array.
// Optional feature macro: HB_TARGET_VARLAT_EN (CR0[3] selects 1x/2x latency).
module hb_target_emu #(
    parameter int          MEM_AW  = 10,
    parameter int          LATENCY = 6,
    parameter logic [15:0] ID0_VAL = 16'h0C81,
    parameter logic [15:0] CR0_RST = 16'h8F1F
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       hb_rstn_i,
    input  logic       hb_csn_i,
    input  logic       hb_clk_i,
    input  logic [7:0] hb_dq_i,
    input  logic       hb_rwds_i,
    output logic [7:0] hb_dq_o,
    output logic       hb_dq_oen,
    output logic       hb_rwds_o,
    output logic       hb_rwds_oen,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_WDATA,
        S_RDATA,
        S_REGW,
        S_DONE
    } state_t;

    // Index of the last skipped latency edge for 2x and 1x latency.
    localparam logic [4:0] GAP2X_LAST = 5'(4 * LATENCY - 3);
    localparam logic [4:0] GAP1X_LAST = 5'(2 * LATENCY - 3);
    localparam logic [15:0] CR0_ADDR  = 16'h0800;

    // Input synchronizers; dq/rwds get the same two stages to stay aligned.
    logic       csn_meta_q, csn_sync_q, csn_prev_q;
    logic       clk_meta_q, clk_sync_q, clk_prev_q;
    logic       rstn_meta_q, rstn_sync_q;
    logic [7:0] dq_meta_q, dq_sync_q;
    logic       rwds_meta_q, rwds_sync_q;

    // Transaction state.
    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [39:0]       ca_q, ca_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [15:0]       reg_addr_q, reg_addr_d;
    logic              is_read_q, is_read_d;
    logic              is_reg_q, is_reg_d;
    logic              linear_q, linear_d;
    logic              lat2x_q, lat2x_d;
    logic              hi_phase_q, hi_phase_d;
    logic [7:0]        wbuf_q, wbuf_d;
    logic              mask_hi_q, mask_hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [15:0]       cr0_q, cr0_d;
    logic [7:0]        dq_o_q, dq_o_d;
    logic              dq_oen_q, dq_oen_d;
    logic              rwds_o_q, rwds_o_d;
    logic              rwds_oen_q, rwds_oen_d;

    // Array interface.
    logic [1:0]  mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rd_word;

    logic        abort;
    logic        edge_det;
    logic        lat2x_now;
    logic [47:0] ca_full;
    logic [31:0] ca_word;
    logic [15:0] reg_rd;
    logic [15:0] rd_word;
    logic [4:0]  gap_last;
    logic        unused_ok;

`ifdef HB_TARGET_VARLAT_EN
    assign lat2x_now = cr0_q[3];
`else
    assign lat2x_now = 1'b1;
`endif

    assign abort     = csn_sync_q || !rstn_sync_q;
    assign edge_det  = clk_sync_q ^ clk_prev_q;
    assign ca_full   = {ca_q, dq_sync_q};
    assign ca_word   = {ca_full[44:16], ca_full[2:0]};
    assign gap_last  = lat2x_q ? GAP2X_LAST : GAP1X_LAST;
    assign mem_wdata = {wbuf_q, dq_sync_q};
    assign reg_rd    = (reg_addr_q == 16'h0000) ? ID0_VAL :
                       (reg_addr_q == CR0_ADDR) ? cr0_q : 16'h0000;
    assign rd_word   = is_reg_q ? reg_rd : mem_rd_word;
    assign unused_ok = ^{ca_full[15:3], ca_word[31:16]};

    // Next burst address: linear wraps the whole array, wrapped stays in a 16-word group.
    function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a,
                                                    input logic lin);
        logic [MEM_AW-1:0] r;
        r = a + MEM_AW'(1);
        if (!lin) begin
            r = {a[MEM_AW-1:4], a[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Byte-lane memories with registered read of the current burst address.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem_q [2**MEM_AW];
            logic [7:0] lane_rd_q;

            // Lane write on commit, registered read every cycle (prefetch).
            always_ff @(posedge wb_clk_i) begin
                if (mem_we[gi]) begin
                    mem_q[addr_q] <= mem_wdata[gi*8 +: 8];
                end
                lane_rd_q <= mem_q[addr_q];
            end

            assign mem_rd_word[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

    // Two-stage synchronizers plus previous-value stage for edge detection.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            csn_meta_q  <= 1'b1;
            csn_sync_q  <= 1'b1;
            csn_prev_q  <= 1'b1;
            clk_meta_q  <= 1'b0;
            clk_sync_q  <= 1'b0;
            clk_prev_q  <= 1'b0;
            rstn_meta_q <= 1'b0;
            rstn_sync_q <= 1'b0;
            dq_meta_q   <= 8'h00;
            dq_sync_q   <= 8'h00;
            rwds_meta_q <= 1'b0;
            rwds_sync_q <= 1'b0;
        end else begin
            csn_meta_q  <= hb_csn_i;
            csn_sync_q  <= csn_meta_q;
            csn_prev_q  <= csn_sync_q;
            clk_meta_q  <= hb_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            rstn_meta_q <= hb_rstn_i;
            rstn_sync_q <= rstn_meta_q;
            dq_meta_q   <= hb_dq_i;
            dq_sync_q   <= dq_meta_q;
            rwds_meta_q <= hb_rwds_i;
            rwds_sync_q <= rwds_meta_q;
        end
    end

    // Transaction state and output registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            ca_q       <= 40'd0;
            addr_q     <= '0;
            reg_addr_q <= 16'h0000;
            is_read_q  <= 1'b0;
            is_reg_q   <= 1'b0;
            linear_q   <= 1'b0;
            lat2x_q    <= 1'b1;
            hi_phase_q <= 1'b1;
            wbuf_q     <= 8'h00;
            mask_hi_q  <= 1'b0;
            lo_q       <= 8'h00;
            cr0_q      <= CR0_RST;
            dq_o_q     <= 8'h00;
            dq_oen_q   <= 1'b1;
            rwds_o_q   <= 1'b0;
            rwds_oen_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ca_q       <= ca_d;
            addr_q     <= addr_d;
            reg_addr_q <= reg_addr_d;
            is_read_q  <= is_read_d;
            is_reg_q   <= is_reg_d;
            linear_q   <= linear_d;
            lat2x_q    <= lat2x_d;
            hi_phase_q <= hi_phase_d;
            wbuf_q     <= wbuf_d;
            mask_hi_q  <= mask_hi_d;
            lo_q       <= lo_d;
            cr0_q      <= cr0_d;
            dq_o_q     <= dq_o_d;
            dq_oen_q   <= dq_oen_d;
            rwds_o_q   <= rwds_o_d;
            rwds_oen_q <= rwds_oen_d;
        end
    end

    // Next-state logic: one step per detected HB clock edge while CS is low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ca_d       = ca_q;
        addr_d     = addr_q;
        reg_addr_d = reg_addr_q;
        is_read_d  = is_read_q;
        is_reg_d   = is_reg_q;
        linear_d   = linear_q;
        lat2x_d    = lat2x_q;
        hi_phase_d = hi_phase_q;
        wbuf_d     = wbuf_q;
        mask_hi_d  = mask_hi_q;
        lo_d       = lo_q;
        cr0_d      = cr0_q;
        dq_o_d     = dq_o_q;
        dq_oen_d   = dq_oen_q;
        rwds_o_d   = rwds_o_q;
        rwds_oen_d = rwds_oen_q;
        mem_we     = 2'b00;

        if (abort) begin
            // CS high or HyperBus reset: drop the transaction, release the bus.
            state_d    = S_IDLE;
            dq_oen_d   = 1'b1;
            rwds_oen_d = 1'b1;
            if (!rstn_sync_q) begin
                cr0_d = CR0_RST;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (csn_prev_q) begin
                        state_d    = S_CA;
                        cnt_d      = 5'd0;
                        lat2x_d    = lat2x_now;
                        rwds_oen_d = 1'b0;
                        rwds_o_d   = lat2x_now;
                        dq_oen_d   = 1'b1;
                    end
                end
                S_CA: begin
                    if (edge_det) begin
                        ca_d  = ca_full[39:0];
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd5) begin
                            is_read_d  = ca_full[47];
                            is_reg_d   = ca_full[46];
                            linear_d   = ca_full[45];
                            addr_d     = ca_word[MEM_AW-1:0];
                            reg_addr_d = ca_word[15:0];
                            cnt_d      = 5'd0;
                            hi_phase_d = 1'b1;
                            rwds_oen_d = 1'b1;
                            state_d    = (!ca_full[47] && ca_full[46]) ? S_REGW : S_LAT;
                        end
                    end
                end
                S_LAT: begin
                    if (edge_det) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == gap_last) begin
                            cnt_d = 5'd0;
                            if (is_read_q) begin
                                state_d    = S_RDATA;
                                dq_oen_d   = 1'b0;
                                rwds_oen_d = 1'b0;
                                rwds_o_d   = 1'b0;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (edge_det) begin
                        if (hi_phase_q) begin
                            wbuf_d     = dq_sync_q;
                            mask_hi_d  = rwds_sync_q;
                            hi_phase_d = 1'b0;
                        end else begin
                            mem_we     = {!mask_hi_q, !rwds_sync_q};
                            addr_d     = next_addr(addr_q, linear_q);
                            hi_phase_d = 1'b1;
                        end
                    end
                end
                S_RDATA: begin
                    if (edge_det) begin
                        rwds_o_d = !rwds_o_q;
                        if (hi_phase_q) begin
                            dq_o_d     = rd_word[15:8];
                            lo_d       = rd_word[7:0];
                            hi_phase_d = 1'b0;
                            if (!is_reg_q) begin
                                addr_d = next_addr(addr_q, linear_q);
                            end
                        end else begin
                            dq_o_d     = lo_q;
                            hi_phase_d = 1'b1;
                        end
                    end
                end
                S_REGW: begin
                    if (edge_det) begin
                        if (hi_phase_q) begin
                            wbuf_d     = dq_sync_q;
                            hi_phase_d = 1'b0;
                        end else begin
                            if (reg_addr_q == CR0_ADDR) begin
                                cr0_d = {wbuf_q, dq_sync_q};
                            end
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    dq_oen_d   = 1'b1;
                    rwds_oen_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign hb_dq_o     = dq_o_q;
    assign hb_dq_oen   = dq_oen_q;
    assign hb_rwds_o   = rwds_o_q;
    assign hb_rwds_oen = rwds_oen_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_hb_target_emu.sv
// Directed bench for hb_target_emu: HyperBus host transactions driven from one
// initial block, read data checked against a queue of expected bytes.
module tb_hb_target_emu;

    localparam int LAT = 6;

    logic       wb_clk = 1'b0;
    logic       wb_rst = 1'b1;
    logic       hb_rstn = 1'b1;
    logic       hb_csn = 1'b1;
    logic       hb_clk = 1'b0;
    logic [7:0] hb_dq = 8'h00;
    logic       hb_rwds = 1'b0;
    logic [7:0] hb_dq_o;
    logic       hb_dq_oen;
    logic       hb_rwds_o;
    logic       hb_rwds_oen;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_xfer = 0;

    logic [8:0]  sb [$];          // {rwds, byte} expected per read data edge
    logic [15:0] bench_cr0 = 16'h8F1F;
    int          exp_gap;
    logic        exp_ca_rwds;

    hb_target_emu dut (
        .wb_clk_i   (wb_clk),
        .wb_rst_i   (wb_rst),
        .hb_rstn_i  (hb_rstn),
        .hb_csn_i   (hb_csn),
        .hb_clk_i   (hb_clk),
        .hb_dq_i    (hb_dq),
        .hb_rwds_i  (hb_rwds),
        .hb_dq_o    (hb_dq_o),
        .hb_dq_oen  (hb_dq_oen),
        .hb_rwds_o  (hb_rwds_o),
        .hb_rwds_oen(hb_rwds_oen),
        .busy_o     (busy)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no end of run, expected $finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One HB clock edge: present data, let it settle, toggle CK, let the target react.
    task automatic hb_edge(input logic [7:0] d, input logic m);
        @(negedge wb_clk);
        hb_dq   = d;
        hb_rwds = m;
        repeat (2) @(negedge wb_clk);
        hb_clk = ~hb_clk;
        repeat (4) @(negedge wb_clk);
    endtask

    task automatic push_word(input logic [15:0] w);
        sb.push_back({1'b1, w[15:8]});
        sb.push_back({1'b0, w[7:0]});
    endtask

    // CS low, check the latency indication on RWDS, then send the 6 CA bytes.
    task automatic start_xfer(input logic rd, input logic rs, input logic lin,
                              input logic [31:0] addr);
        logic [47:0] ca;
        logic        lat2x;
`ifdef HB_TARGET_VARLAT_EN
        lat2x = bench_cr0[3];
`else
        lat2x = 1'b1;
`endif
        exp_gap     = lat2x ? 4 * LAT - 2 : 2 * LAT - 2;
        exp_ca_rwds = lat2x;
        ca = {rd, rs, lin, addr[31:3], 13'd0, addr[2:0]};
        @(negedge wb_clk);
        hb_csn = 1'b0;
        repeat (4) @(negedge wb_clk);
        chk("busy_ca", busy, 1'b1);
        chk("ca_rwds_oen", hb_rwds_oen, 1'b0);
        chk("ca_rwds", hb_rwds_o, exp_ca_rwds);
        for (int i = 0; i < 6; i++) begin
            hb_edge(ca[47 - 8*i -: 8], 1'b0);
        end
    endtask

    // Skip the latency edges; for reads the bus must turn around exactly on the last one.
    task automatic gap(input int n, input logic rd);
        for (int i = 0; i < n; i++) begin
            hb_edge(8'h00, 1'b0);
            if (rd && i == n - 2) chk("gap_oen_before", hb_dq_oen, 1'b1);
            if (rd && i == n - 1) chk("gap_oen_last", hb_dq_oen, 1'b0);
            if (!rd && i == n - 1) chk("wgap_oen", hb_dq_oen, 1'b1);
        end
    endtask

    task automatic rd_bytes(input int n);
        logic [8:0] e;
        for (int i = 0; i < n; i++) begin
            hb_edge(8'h00, 1'b0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rd_dq", hb_dq_o, e[7:0]);
                chk("rd_rwds", hb_rwds_o, e[8]);
                chk("rd_oen", hb_dq_oen, 1'b0);
            end
        end
    endtask

    task automatic wr_word(input logic [15:0] w, input logic m_hi, input logic m_lo);
        hb_edge(w[15:8], m_hi);
        hb_edge(w[7:0], m_lo);
    endtask

    task automatic end_xfer(input string what);
        @(negedge wb_clk);
        hb_csn = 1'b1;
        repeat (4) @(negedge wb_clk);
        chk("end_busy", busy, 1'b0);
        chk("end_dq_oen", hb_dq_oen, 1'b1);
        chk("end_rwds_oen", hb_rwds_oen, 1'b1);
        n_xfer++;
        $display("xfer %0d: %s (checks %0d, bad %0d)", n_xfer, what, n_cmp, n_bad);
    endtask

    task automatic rd_xfer(input logic rs, input logic lin, input logic [31:0] addr,
                           input int nwords, input string what);
        start_xfer(1'b1, rs, lin, addr);
        gap(exp_gap, 1'b1);
        rd_bytes(2 * nwords);
        end_xfer(what);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge wb_clk);
        chk("rst_dq_oen", hb_dq_oen, 1'b1);
        chk("rst_rwds_oen", hb_rwds_oen, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dq", hb_dq_o, 8'h00);
        chk("rst_rwds", hb_rwds_o, 1'b0);
        wb_rst = 1'b0;
        repeat (5) @(negedge wb_clk);
        chk("idle_busy", busy, 1'b0);

        push_word(16'h8F1F);
        rd_xfer(1'b1, 1'b1, 32'h0800, 1, "reg read CR0 after reset");

        // Preload words used by later reads.
        start_xfer(1'b0, 1'b0, 1'b1, 32'h010);
        gap(exp_gap, 1'b0);
        wr_word(16'hA55A, 1'b0, 1'b0);
        wr_word(16'h1234, 1'b0, 1'b0);
        wr_word(16'h5A5A, 1'b0, 1'b0);
        end_xfer("write 0x010 A55A 1234 5A5A");

        start_xfer(1'b0, 1'b0, 1'b1, 32'h01E);
        gap(exp_gap, 1'b0);
        wr_word(16'hBEEF, 1'b0, 1'b0);
        wr_word(16'hCAFE, 1'b0, 1'b0);
        end_xfer("write 0x01E BEEF CAFE");

        start_xfer(1'b0, 1'b0, 1'b1, 32'h3FF);
        gap(exp_gap, 1'b0);
        wr_word(16'h7E81, 1'b0, 1'b0);
        wr_word(16'h0F0F, 1'b0, 1'b0);
        end_xfer("write 0x3FF 7E81, 0x000 0F0F");

        start_xfer(1'b0, 1'b0, 1'b1, 32'h020);
        gap(exp_gap, 1'b0);
        wr_word(16'h1234, 1'b0, 1'b0);
        end_xfer("write 0x020 1234");

        // Linear read back with latency check inside gap().
        push_word(16'hA55A);
        push_word(16'h1234);
        rd_xfer(1'b0, 1'b1, 32'h010, 2, "read linear 0x010 x2");

        // Masked write: low byte kept.
        start_xfer(1'b0, 1'b0, 1'b1, 32'h020);
        gap(exp_gap, 1'b0);
        wr_word(16'hFFFF, 1'b0, 1'b1);
        end_xfer("masked write 0x020 FFFF low masked");
        push_word(16'hFF34);
        rd_xfer(1'b0, 1'b1, 32'h020, 1, "read 0x020");

        // Wrapped burst: 0x01E, 0x01F, 0x010, 0x011.
        push_word(16'hBEEF);
        push_word(16'hCAFE);
        push_word(16'hA55A);
        push_word(16'h1234);
        rd_xfer(1'b0, 1'b0, 32'h01E, 4, "read wrapped 0x01E x4");

        // Linear burst wrapping past the top of the array.
        push_word(16'h7E81);
        push_word(16'h0F0F);
        rd_xfer(1'b0, 1'b1, 32'h3FF, 2, "read linear 0x3FF x2");

        // Read aborted after one byte: bus released exactly one clock after sync.
        push_word(16'hA55A);
        start_xfer(1'b1, 1'b0, 1'b1, 32'h010);
        gap(exp_gap, 1'b1);
        rd_bytes(1);
        sb.delete();
        @(negedge wb_clk);
        hb_csn = 1'b1;
        repeat (2) @(negedge wb_clk);
        chk("abort_oen_hold", hb_dq_oen, 1'b0);
        @(negedge wb_clk);
        chk("abort_dq_oen", hb_dq_oen, 1'b1);
        chk("abort_rwds_oen", hb_rwds_oen, 1'b1);
        chk("abort_busy", busy, 1'b0);
        n_xfer++;
        $display("xfer %0d: read 0x010 aborted after 1 byte (checks %0d, bad %0d)", n_xfer, n_cmp, n_bad);
        repeat (4) @(negedge wb_clk);

        // Write aborted after 3 data edges: second word must not land.
        start_xfer(1'b0, 1'b0, 1'b1, 32'h011);
        gap(exp_gap, 1'b0);
        wr_word(16'h4321, 1'b0, 1'b0);
        hb_edge(8'h99, 1'b0);
        end_xfer("write 0x011 aborted after 3 edges");
        push_word(16'h4321);
        push_word(16'h5A5A);
        rd_xfer(1'b0, 1'b1, 32'h011, 2, "read 0x011 x2");

        // Register write to CR0, then register reads.
        start_xfer(1'b0, 1'b1, 1'b0, 32'h0800);
        wr_word(16'h8F17, 1'b0, 1'b0);
        end_xfer("reg write CR0 8F17");
        bench_cr0 = 16'h8F17;
        push_word(16'h8F17);
        rd_xfer(1'b1, 1'b1, 32'h0800, 1, "reg read CR0");
        push_word(16'h0C81);
        rd_xfer(1'b1, 1'b1, 32'h0000, 1, "reg read ID0");
        push_word(16'h0000);
        rd_xfer(1'b1, 1'b1, 32'h0004, 1, "reg read unmapped");

        // HyperBus reset restores CR0.
        @(negedge wb_clk);
        hb_rstn = 1'b0;
        repeat (6) @(negedge wb_clk);
        hb_rstn = 1'b1;
        repeat (4) @(negedge wb_clk);
        bench_cr0 = 16'h8F1F;
        push_word(16'h8F1F);
        rd_xfer(1'b1, 1'b1, 32'h0800, 1, "reg read CR0 after hb_rstn");

        // System reset in the middle of a read.
        start_xfer(1'b1, 1'b0, 1'b1, 32'h010);
        gap(4, 1'b0);
        @(negedge wb_clk);
        wb_rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rwds_oen", hb_rwds_oen, 1'b1);
        chk("mid_rst_dq_oen", hb_dq_oen, 1'b1);
        hb_csn = 1'b1;
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;
        repeat (4) @(negedge wb_clk);
        n_xfer++;
        $display("xfer %0d: read 0x010 cut by wb_rst (checks %0d, bad %0d)", n_xfer, n_cmp, n_bad);

        // Array survives wb_rst.
        push_word(16'h7E81);
        rd_xfer(1'b0, 1'b1, 32'h3FF, 1, "read 0x3FF after wb_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
